// File: rtl/pipe_issue_ctrl.sv
// Issue controller for the 4-stage pipeline: RAW hazard interlock against an
// in-flight destination window, single registered issue slot, illegal-func drop and stats.
module pipe_issue_ctrl #(
    parameter int WB_LAT = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_rs1,
    input  logic [3:0]       in_rs2,
    input  logic [3:0]       in_rd,
    input  logic [3:0]       in_func,
    input  logic [7:0]       in_addr,
    output logic             issue_valid,
    output logic [3:0]       issue_rs1,
    output logic [3:0]       issue_rs2,
    output logic [3:0]       issue_rd,
    output logic [3:0]       issue_func,
    output logic [7:0]       issue_addr,
    output logic             err_illegal,
    output logic             idle,
    output logic [CNT_W-1:0] issue_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [WB_LAT-1:0] slot_v;
    logic [3:0]        slot_rd [WB_LAT];
    logic              use_rs1;
    logic              use_rs2;
    logic              illegal;
    logic              hazard;
    logic              accept;

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        illegal = 1'b0;
        case (in_func)
            4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd7: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            4'd3, 4'd8, 4'd10, 4'd11: use_rs1 = 1'b1;
            4'd4, 4'd9:               use_rs2 = 1'b1;
            default:                  illegal = 1'b1;
        endcase
    end

    // Only older in-flight destinations are compared; the offered rd is never checked.
    always_comb begin
        hazard = 1'b0;
        for (int unsigned k = 0; k < WB_LAT; k++) begin
            if (slot_v[k] && ((use_rs1 && (slot_rd[k] == in_rs1)) ||
                              (use_rs2 && (slot_rd[k] == in_rs2))))
                hazard = 1'b1;
        end
    end

    assign in_ready    = en & ~hazard;
    assign accept      = in_valid & in_ready;
    assign issue_valid = slot_v[0];
    assign idle        = ~|slot_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_v <= '0;
            for (int unsigned k = 0; k < WB_LAT; k++)
                slot_rd[k] <= '0;
        end else begin
            slot_v[0]  <= accept & ~illegal;
            slot_rd[0] <= in_rd;
            for (int unsigned k = 1; k < WB_LAT; k++) begin
                slot_v[k]  <= slot_v[k-1];
                slot_rd[k] <= slot_rd[k-1];
            end
        end
    end

    // Fields only load on a legal accept so bubbles leave the last issue visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_rs1  <= '0;
            issue_rs2  <= '0;
            issue_rd   <= '0;
            issue_func <= '0;
            issue_addr <= '0;
        end else if (accept && !illegal) begin
            issue_rs1  <= in_rs1;
            issue_rs2  <= in_rs2;
            issue_rd   <= in_rd;
            issue_func <= in_func;
            issue_addr <= in_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_illegal <= 1'b0;
            issue_cnt   <= '0;
            stall_cnt   <= '0;
        end else begin
            err_illegal <= accept & illegal;
            if (accept && !illegal)
                issue_cnt <= issue_cnt + 1'b1;
            if (en && in_valid && hazard)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Bench for pipe_issue_ctrl: vector table plus hand sequences, issue scoreboard.
module tb_pipe_issue_ctrl;

    localparam int WB_LAT = 2;
    localparam int CNT_W  = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       in_rs1 = '0, in_rs2 = '0, in_rd = '0, in_func = '0;
    logic [7:0]       in_addr = '0;
    logic             issue_valid;
    logic [3:0]       issue_rs1, issue_rs2, issue_rd, issue_func;
    logic [7:0]       issue_addr;
    logic             err_illegal;
    logic             idle;
    logic [CNT_W-1:0] issue_cnt, stall_cnt;

    pipe_issue_ctrl #(.WB_LAT(WB_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_func(in_func), .in_addr(in_addr),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd(issue_rd), .issue_func(issue_func), .issue_addr(issue_addr),
        .err_illegal(err_illegal), .idle(idle), .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [3:0] rd;
        logic [3:0] func;
        logic [7:0] addr;
    } instr_t;

    typedef struct {
        instr_t ins;
        int     stall;
        bit     drain;
    } vec_t;

    instr_t exp_q[$];
    instr_t mon_exp;
    int     checks = 0;
    int     fails = 0;
    int     exp_issue = 0;
    int     exp_stall = 0;
    vec_t   tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Scoreboard: every issued instruction must match the oldest expected entry.
    always @(posedge clk) begin
        #2;
        if (rst_n && issue_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_issue: actual issue_valid=1 fields=%0h required no issue",
                         {issue_rs1, issue_rs2, issue_rd, issue_func, issue_addr});
            end else begin
                mon_exp = exp_q.pop_front();
                chk("issue_fields", {8'h0, issue_rs1, issue_rs2, issue_rd, issue_func, issue_addr},
                    {8'h0, mon_exp});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Entered at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic offer(input instr_t i, input int exp_st, input string nm);
        int n;
        n = 0;
        {in_rs1, in_rs2, in_rd, in_func, in_addr} = i;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 20) begin
            in_valid = 1'b0;
            chk({nm, "_timeout"}, 32'(n), 32'(exp_st));
            #(-0);
            return;
        end
        if (i.func < 4'd12) begin
            exp_q.push_back(i);
            exp_issue++;
        end
        exp_stall += exp_st;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk(nm, 32'(n), 32'(exp_st));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{'{4'd1, 4'd2, 4'd4, 4'd0, 8'h20}, 0, 1'b1};
        tbl[1] = '{'{4'd4, 4'd1, 4'd2, 4'd0, 8'h21}, 2, 1'b0};
        tbl[2] = '{'{4'd1, 4'd2, 4'd4, 4'd2, 8'h30}, 0, 1'b1};
        tbl[3] = '{'{4'd4, 4'd9, 4'd3, 4'd4, 8'h31}, 0, 1'b0};
        tbl[4] = '{'{4'd1, 4'd2, 4'd4, 4'd5, 8'h40}, 0, 1'b1};
        tbl[5] = '{'{4'd4, 4'd9, 4'd3, 4'd3, 8'h41}, 2, 1'b0};
        tbl[6] = '{'{4'd5, 4'd5, 4'd5, 4'd6, 8'h50}, 0, 1'b1};
        tbl[7] = '{'{4'd8, 4'd8, 4'd8, 4'd10, 8'h51}, 0, 1'b0};
        tbl[8] = '{'{4'd5, 4'd0, 4'd1, 4'd9, 8'h52}, 0, 1'b0};
        tbl[9] = '{'{4'd8, 4'd0, 4'd2, 4'd11, 8'h53}, 1, 1'b0};

        #2;
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_idle", idle, 1);
        chk("rst_err", err_illegal, 0);
        chk("rst_issue_cnt", issue_cnt, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_fields", {issue_rs1, issue_rs2, issue_rd, issue_func, issue_addr}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back independent issue, then idle after the window drains.
        offer('{4'd2, 4'd3, 4'd4, 4'd0, 8'h10}, 0, "b2b_first");
        offer('{4'd5, 4'd6, 4'd7, 4'd1, 8'h11}, 0, "b2b_second");
        chk("b2b_issue_cnt", issue_cnt, 2);
        chk("b2b_stall_cnt", stall_cnt, 0);
        chk("b2b_idle_0", idle, 0);
        tick(1);
        chk("b2b_idle_1", idle, 0);
        tick(1);
        chk("b2b_idle_2", idle, 1);

        for (int v = 0; v < 10; v++) begin
            if (tbl[v].drain) tick(WB_LAT + 1);
            offer(tbl[v].ins, tbl[v].stall, $sformatf("vec%0d_stall", v));
        end
        chk("tbl_issue_cnt", issue_cnt, 32'(exp_issue));
        chk("tbl_stall_cnt", stall_cnt, 32'(exp_stall));

        // Illegal func behind a producer: no hazard, dropped, one-cycle error pulse.
        tick(WB_LAT + 1);
        offer('{4'd1, 4'd2, 4'd4, 4'd0, 8'h60}, 0, "ill_producer");
        offer('{4'd4, 4'd4, 4'd9, 4'd13, 8'h61}, 0, "ill_accept");
        chk("ill_err_pulse", err_illegal, 1);
        chk("ill_issue_valid", issue_valid, 0);
        chk("ill_fields_hold", issue_addr, 8'h60);
        chk("ill_issue_cnt", issue_cnt, 32'(exp_issue));
        offer('{4'd1, 4'd2, 4'd3, 4'd0, 8'h62}, 0, "ill_follow");
        chk("ill_err_clear", err_illegal, 0);
        chk("ill_follow_valid", issue_valid, 1);

        // Enable low: no acceptance, stall count frozen, window drains.
        tick(WB_LAT + 1);
        offer('{4'd1, 4'd2, 4'd3, 4'd0, 8'h70}, 0, "en_producer");
        en = 1'b0;
        {in_rs1, in_rs2, in_rd, in_func, in_addr} = {4'd3, 4'd1, 4'd5, 4'd0, 8'h71};
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("en_low_ready", in_ready, 0);
            chk("en_low_idle", idle, (k >= WB_LAT) ? 1 : 0);
            chk("en_low_stall_cnt", stall_cnt, 32'(exp_stall));
            @(posedge clk);
            #1;
        end
        en = 1'b1;
        offer('{4'd3, 4'd1, 4'd5, 4'd0, 8'h71}, 0, "en_resume");

        // Asynchronous reset with two instructions in flight.
        tick(WB_LAT + 1);
        offer('{4'd1, 4'd2, 4'd6, 4'd0, 8'h80}, 0, "rst_a");
        offer('{4'd1, 4'd2, 4'd7, 4'd0, 8'h81}, 0, "rst_b");
        #2;
        {in_rs1, in_rs2, in_rd, in_func, in_addr} = {4'd7, 4'd6, 4'd1, 4'd0, 8'h82};
        in_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("arst_issue_valid", issue_valid, 0);
        chk("arst_idle", idle, 1);
        chk("arst_issue_cnt", issue_cnt, 0);
        chk("arst_stall_cnt", stall_cnt, 0);
        exp_q.delete();
        exp_issue = 0;
        exp_stall = 0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back('{4'd7, 4'd6, 4'd1, 4'd0, 8'h82});
        exp_issue = 1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("arst_pending_issue", issue_valid, 1);
        chk("arst_issue_cnt_after", issue_cnt, 1);

        tick(WB_LAT + 2);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        chk("final_idle", idle, 1);
        chk("final_stall_cnt", stall_cnt, 32'(exp_stall));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/pipe_issue_ctrl.md
Name: pipe_issue_ctrl

Overview:
Issue controller placed in front of the 4-stage register/ALU/writeback/memory pipeline. It accepts instructions (rs1, rs2, rd, func, addr) over a valid/ready handshake and detects read-after-write hazards against in-flight destinations. It inserts bubbles until each hazard clears, then drives one registered issue slot into pipeline stage 1. It also rejects illegal function codes and keeps issue and stall statistics.

Parameters:
WB_LAT, 2, cycles an issued instruction's rd stays in flight; its result is readable WB_LAT cycles after issue (legal 1..8)
CNT_W, 16, width of the statistics counters

Ports:
clk  input  1  single system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  issue enable; when low, no new acceptance, in-flight slots keep draining
in_valid  input  1  instruction offered
in_ready  output  1  controller can accept this cycle (combinational)
in_rs1  input  4  source register A
in_rs2  input  4  source register B
in_rd  input  4  destination register
in_func  input  4  ALU function code
in_addr  input  8  memory store address
issue_valid  output  1  registered; issue slot holds a real instruction
issue_rs1  output  4  registered copy of accepted rs1
issue_rs2  output  4  registered copy of accepted rs2
issue_rd  output  4  registered copy of accepted rd
issue_func  output  4  registered copy of accepted func
issue_addr  output  8  registered copy of accepted addr
err_illegal  output  1  one-cycle pulse; an illegal func was accepted and dropped
idle  output  1  no valid instruction in any in-flight slot
issue_cnt  output  CNT_W  count of instructions issued
stall_cnt  output  CNT_W  count of hazard stall cycles

Behaviour:
- Reset (rst_n low, asynchronous): all slots invalid; issue_valid=0; issue_* fields=0; err_illegal=0; counters=0; idle=1. Reset asserted mid-operation discards every in-flight instruction immediately.
- In-flight window: WB_LAT slots, each holding {v, rd}. Slot0 is the issue register. Every clock, slot k moves to slot k+1 and the last slot is discarded. Slot0 loads the accepted legal instruction, otherwise a bubble (v=0).
- Source usage by func:
  - 0,1,2,5,6,7 use rs1 and rs2.
  - 3,8,10,11 use rs1 only.
  - 4,9 use rs2 only.
  - 12..15 are illegal and use no sources.
- hazard = some valid slot has rd equal to a used source of the offered instruction.
- in_ready = en & !hazard. Acceptance = in_valid & in_ready at a rising edge.
- Latency: an instruction accepted at edge E appears on issue_* with issue_valid=1 from E until the next edge. Back-to-back independent instructions issue every cycle.
- A dependent consumer is accepted only once its producer has left every slot. With WB_LAT=2, the consumer issues 3 cycles after the producer, leaving 2 bubbles.
- Illegal func (12..15):
  - Accepted; never hazards.
  - Slot0 loads a bubble and issue_valid=0.
  - err_illegal=1 for the following cycle.
  - issue_cnt does not increment.
- When issue_valid=0, issue_* fields hold their previous values. Downstream must qualify them with issue_valid.
- issue_cnt increments on each legal acceptance. stall_cnt increments each cycle with en & in_valid & hazard. Both counters wrap modulo 2^CNT_W.
- en low: in_ready=0, stall_cnt frozen, slots continue to shift. idle rises once the window drains.
- idle = NOR of all slot valid bits.
- An instruction whose rd equals its own source is not a hazard with itself. Only older in-flight instructions are checked.
- No write-after-write check: the pipeline retires writes in order.

Test Plan:
- Reset, then rs1=2, rs2=3, rd=4, func=0 followed by rs1=5, rs2=6, rd=7, func=1 back-to-back -> issue_valid high for 2 consecutive cycles; issue_cnt=2; stall_cnt=0; idle=1 two cycles after the last issue.
- Producer rd=4, func=0, then consumer rs1=4, rs2=1, rd=2, func=0 held valid -> in_ready low for 2 cycles; 2 bubbles between issues; stall_cnt=2.
- Consumer func=4 (B only) with rs1=4, rs2=9 after producer rd=4 -> no stall, issued next cycle. Same consumer with func=3 -> stalls 2 cycles.
- func=13 offered -> accepted in one cycle; issue_valid=0; err_illegal pulses once; issue_cnt unchanged. A following func=0 issues the next cycle.
- en=0 with in_valid=1 for 5 cycles -> in_ready=0, no issue, stall_cnt unchanged, idle=1 after WB_LAT cycles. Then en=1 -> instruction issues next edge.
- rst_n pulsed low mid-stream with 2 instructions in flight -> issue_valid=0, idle=1 and counters=0 immediately, without waiting for a clock edge. A pending dependent instruction is accepted on the first edge after release.
